serial_frame_tx: RTL and testbench
==================================

Name: serial_frame_tx

Overview:
- Upstream stimulus stage for the serial port-demux receiver.
- Turns a parallel request (port id, length, payload) into the single-wire frame that the receiver's SerIn consumes.
- Frame format: a 0 start bit, 2 port bits MSB first, 4 length bits MSB first, then `len` payload bits MSB first. Idle line is 1.
- Bit timing is paced by the same one-pulsed clkEn strobe the receiver uses, so on a board both blocks step together from the push-button.

Parameters:
- ID_W, 2, port-select field width; selects P0..P3 downstream.
- LEN_W, 4, length field width.
- DATA_W, 15, payload register width; must be at least 2**LEN_W-1.

Ports:
- clk  in  1  system clock; all state changes on rising edge.
- rst  in  1  asynchronous, active-low reset.
- clkEn  in  1  bit-advance strobe, one clk cycle wide; all serial progress happens only on clk edges where clkEn=1.
- start  in  1  request pulse, any width, sampled every clk.
- port  in  ID_W  destination port id, captured at acceptance.
- len  in  LEN_W  payload bit count 0..15, captured at acceptance.
- data  in  DATA_W  payload; bits data[len-1]..data[0] are sent, upper bits are ignored.
- SerOut  out  1  serial line to the receiver's SerIn.
- busy  out  1  high from acceptance until return to IDLE.
- done  out  1  one-clk pulse when a frame completes.
- frameCnt  out  8  completed-frame count, for SSD display; wraps 255->0.

Behaviour:
Reset:
- rst=0 clears everything asynchronously: state=IDLE, SerOut=1, busy=0, done=0, frameCnt=0, pending=0, shift register and counters=0.
- Applies mid-frame too. The partial frame is abandoned and the line returns to 1 immediately.

Acceptance:
- In IDLE with pending=0, a clk edge with start=1 sets pending=1 and latches port, len, data into the shift registers. busy rises on that edge.
- start while busy=1 is ignored; there is no queueing.

States (each transition occurs only on a clk edge with clkEn=1 unless noted):
- IDLE: SerOut=1. If pending, go to START; clear pending.
- START: SerOut=0 for exactly one clkEn beat. Go to PORT with bit counter=ID_W-1.
- PORT: SerOut=port[cnt]. cnt decrements each beat. At cnt=0 go to LEN with cnt=LEN_W-1.
- LEN: SerOut=len[cnt]. At cnt=0: go to DATA with cnt=len-1 if len>0; otherwise go to FIN.
- DATA: SerOut=data[cnt]. At cnt=0 go to FIN.
- FIN: SerOut=1. On entry edge, done=1 for that single clk cycle and frameCnt increments. On the next clkEn edge go to IDLE and drop busy.

Timing and output rules:
- SerOut is registered, and each bit is held for one full clkEn period.
- Frame length is 1+ID_W+LEN_W+len beats. Total clkEn beats from acceptance to busy=0 is len+9.
- clkEn=1 coincident with start in IDLE: acceptance happens on that edge, and START begins at the next clkEn (no same-edge start bit).
- done is forced 0 on every cycle other than the FIN entry edge, regardless of clkEn width.
- clkEn held high continuously is legal; the block then advances one bit per clk.
- The bit counter is LEN_W bits wide. No arithmetic wraps except frameCnt.

Decomposition:
- Shared package holds:
  - State encoding as localparams: S_IDLE, S_START, S_PORT, S_LEN, S_DATA, S_FIN (3 bits).
  - ID_W/LEN_W defaults and the frame header length constant HDR_BITS=1+ID_W+LEN_W, all shared with the receiver controller.
- Natural split: serial_frame_tx_ctrl (FSM, counter, busy/done) plus the datapath (field shift registers, SerOut mux, frameCnt) in the top.

Test Plan:
- Reset: hold rst=0 while clkEn toggles, then release -> SerOut=1, busy=0, done=0, frameCnt=0 throughout.
- Basic frame: port=2'b10, len=4'd3, data=15'b101, clkEn every 4th clk -> per-beat SerOut 0,1,0,0,0,1,1,1,0,1, then 1. One done pulse, busy low after 12 beats, frameCnt=1.
- Zero length: port=2'b01, len=0 -> SerOut 0,0,1,0,0,0,0, then FIN. done after 7 bit beats, no payload bits.
- Max length: len=15, data=15'h5555, clkEn continuous -> 22 bits on the line, with payload alternating 1,0,...,1. busy high for 24 clk cycles.
- Busy rejection and reset mid-frame:
  - start re-pulsed during the DATA state -> no second frame, frameCnt increments by only 1.
  - rst=0 asserted during LEN -> SerOut=1 asynchronously, no done, frameCnt unchanged.
- Loopback: SerOut tied to the receiver top, 4 frames to ports 0..3 -> each P output is selected once, Done pulses 4 times, frameCnt=4.

Source files
------------

// File: rtl/serial_frame_tx_pkg.sv
// Shared constants for the serial frame transmitter and the matching receiver controller.
package serial_frame_tx_pkg;

  localparam int DEF_ID_W   = 2;
  localparam int DEF_LEN_W  = 4;
  localparam int DEF_DATA_W = 15;
  localparam int HDR_BITS   = 1 + DEF_ID_W + DEF_LEN_W;

  typedef enum logic [2:0] {
    S_IDLE  = 3'd0,
    S_START = 3'd1,
    S_PORT  = 3'd2,
    S_LEN   = 3'd3,
    S_DATA  = 3'd4,
    S_FIN   = 3'd5
  } tx_state_e;

endpackage

// File: rtl/serial_frame_tx_ctrl.sv
// Frame sequencer: walks START/PORT/LEN/DATA/FIN one clkEn beat at a time and owns busy/done/frameCnt.
module serial_frame_tx_ctrl
  import serial_frame_tx_pkg::*;
#(
  parameter int ID_W  = DEF_ID_W,
  parameter int LEN_W = DEF_LEN_W
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             clkEn,
  input  logic             start,
  input  logic [LEN_W-1:0] len,
  output logic             load,
  output logic             busy,
  output logic             done,
  output logic [7:0]       frameCnt
);

  tx_state_e        stateQ;
  logic [LEN_W-1:0] cntQ;
  logic [LEN_W-1:0] lenQ;
  logic             pendingQ;
  logic             busyQ;
  logic             doneQ;
  logic [7:0]       frameCntQ;

  // busy is raised on acceptance, so it doubles as the "not accepting" flag.
  assign load     = start && !busyQ;
  assign busy     = busyQ;
  assign done     = doneQ;
  assign frameCnt = frameCntQ;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      stateQ    <= S_IDLE;
      cntQ      <= '0;
      lenQ      <= '0;
      pendingQ  <= 1'b0;
      busyQ     <= 1'b0;
      doneQ     <= 1'b0;
      frameCntQ <= 8'd0;
    end else begin
      doneQ <= 1'b0;
      if (load) begin
        pendingQ <= 1'b1;
        busyQ    <= 1'b1;
        lenQ     <= len;
      end
      if (clkEn) begin
        case (stateQ)
          S_IDLE: begin
            if (pendingQ) begin
              stateQ   <= S_START;
              pendingQ <= 1'b0;
            end
          end
          S_START: begin
            stateQ <= S_PORT;
            cntQ   <= LEN_W'(ID_W - 1);
          end
          S_PORT: begin
            if (cntQ == '0) begin
              stateQ <= S_LEN;
              cntQ   <= LEN_W'(LEN_W - 1);
            end else begin
              cntQ <= cntQ - 1'b1;
            end
          end
          S_LEN: begin
            if (cntQ != '0) begin
              cntQ <= cntQ - 1'b1;
            end else if (lenQ != '0) begin
              stateQ <= S_DATA;
              cntQ   <= lenQ - 1'b1;
            end else begin
              stateQ    <= S_FIN;
              doneQ     <= 1'b1;
              frameCntQ <= frameCntQ + 8'd1;
            end
          end
          S_DATA: begin
            if (cntQ == '0) begin
              stateQ    <= S_FIN;
              doneQ     <= 1'b1;
              frameCntQ <= frameCntQ + 8'd1;
            end else begin
              cntQ <= cntQ - 1'b1;
            end
          end
          S_FIN: begin
            stateQ <= S_IDLE;
            busyQ  <= 1'b0;
          end
          default: stateQ <= S_IDLE;
        endcase
      end
    end
  end

endmodule

// File: rtl/serial_frame_tx.sv
// Serial frame transmitter: start bit, port, length and payload shifted out MSB first on clkEn beats.
module serial_frame_tx
  import serial_frame_tx_pkg::*;
#(
  parameter int ID_W   = DEF_ID_W,
  parameter int LEN_W  = DEF_LEN_W,
  parameter int DATA_W = DEF_DATA_W
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              clkEn,
  input  logic              start,
  input  logic [ID_W-1:0]   port,
  input  logic [LEN_W-1:0]  len,
  input  logic [DATA_W-1:0] data,
  output logic              SerOut,
  output logic              busy,
  output logic              done,
  output logic [7:0]        frameCnt
);

  localparam int FRAME_W = 1 + ID_W + LEN_W + DATA_W;

  logic               load;
  logic               busyInt;
  logic [DATA_W-1:0]  payloadAligned;
  logic [FRAME_W-1:0] frameQ;
  logic               serOutQ;

  serial_frame_tx_ctrl #(
    .ID_W  (ID_W),
    .LEN_W (LEN_W)
  ) u_ctrl (
    .clk      (clk),
    .rst      (rst),
    .clkEn    (clkEn),
    .start    (start),
    .len      (len),
    .load     (load),
    .busy     (busyInt),
    .done     (done),
    .frameCnt (frameCnt)
  );

  // Payload bits move to the top of the field and the unused tail is filled with
  // ones, so the line naturally idles high once the last real bit has gone out.
  always_comb begin
    payloadAligned = (data << (DATA_W - int'(len))) | ({DATA_W{1'b1}} >> len);
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      frameQ   <= '0;
      serOutQ  <= 1'b1;
    end else if (load) begin
      frameQ <= {1'b0, port, len, payloadAligned};
    end else if (busyInt && clkEn) begin
      serOutQ <= frameQ[FRAME_W-1];
      frameQ  <= {frameQ[FRAME_W-2:0], 1'b1};
    end
  end

  assign SerOut = serOutQ;
  assign busy   = busyInt;

endmodule

// File: tb/tb_serial_frame_tx.sv
// Self-checking bench for serial_frame_tx: beat-level frame model plus directed frame scenarios.
module tb_serial_frame_tx;

  logic        clk   = 1'b0;
  logic        rst   = 1'b1;
  logic        clkEn = 1'b0;
  logic        start = 1'b0;
  logic [1:0]  port  = '0;
  logic [3:0]  len   = '0;
  logic [14:0] data  = '0;
  logic        SerOut;
  logic        busy;
  logic        done;
  logic [7:0]  frameCnt;

  int testsRun    = 0;
  int testsFailed = 0;
  int enDiv       = 2;
  int divCnt      = 0;
  bit checkEn     = 1'b0;

  bit mBusy    = 1'b0;
  bit mSer     = 1'b1;
  bit mDone    = 1'b0;
  int mCnt     = 0;
  int beat     = 0;
  int frameLen = 0;
  bit frameBits [0:21];

  bit lastEn     = 1'b0;
  bit busyPrev   = 1'b0;
  bit captured [$];
  int doneCount  = 0;
  int busyCycles = 0;

  int doneBefore;
  int busyBefore;

  serial_frame_tx dut (
    .clk      (clk),
    .rst      (rst),
    .clkEn    (clkEn),
    .start    (start),
    .port     (port),
    .len      (len),
    .data     (data),
    .SerOut   (SerOut),
    .busy     (busy),
    .done     (done),
    .frameCnt (frameCnt)
  );

  always #5 clk = ~clk;

  always @(negedge clk) begin
    divCnt = divCnt + 1;
    clkEn  = (divCnt % enDiv) == 0;
  end

  // Frame model: a frame is a list of line bits; beat k after acceptance shows bit k-1,
  // the beat after the last bit is the done pulse, and the one after that ends busy.
  always @(posedge clk or negedge rst) begin
    if (!rst) begin
      mBusy = 1'b0;
      mSer  = 1'b1;
      mDone = 1'b0;
      mCnt  = 0;
      beat  = 0;
    end else begin
      mDone = 1'b0;
      if (mBusy && clkEn) begin
        beat = beat + 1;
        mSer = (beat <= frameLen) ? frameBits[beat-1] : 1'b1;
        if (beat == frameLen + 1) begin
          mDone = 1'b1;
          mCnt  = (mCnt + 1) % 256;
        end
        if (beat == frameLen + 2) mBusy = 1'b0;
      end else if (!mBusy && start) begin
        frameBits[0] = 1'b0;
        frameBits[1] = port[1];
        frameBits[2] = port[0];
        for (int i = 0; i < 4; i++) frameBits[3+i] = len[3-i];
        for (int i = 0; i < int'(len); i++) frameBits[7+i] = data[int'(len)-1-i];
        frameLen = 7 + int'(len);
        beat     = 0;
        mBusy    = 1'b1;
      end
    end
  end

  task automatic checkOutput(input string name, input logic [31:0] actual, input logic [31:0] expected);
    testsRun++;
    if (actual !== expected) begin
      testsFailed++;
      $display("[TB] FAIL %s: got %0d, expected %0d at %0t", name, actual, expected, $time);
    end
  endtask

  always @(negedge clk) begin
    if (checkEn) begin
      checkOutput("SerOut", 32'(SerOut), 32'(mSer));
      checkOutput("busy", 32'(busy), 32'(mBusy));
      checkOutput("done", 32'(done), 32'(mDone));
      checkOutput("frameCnt", 32'(frameCnt), 32'(mCnt));
    end
  end

  always @(posedge clk) lastEn <= clkEn;

  always @(negedge clk) begin
    if (lastEn && busyPrev) captured.push_back(SerOut);
    if (done) doneCount++;
    if (busy) busyCycles++;
    busyPrev = busy;
  end

  function automatic logic [31:0] packCaptured();
    logic [31:0] v = '0;
    foreach (captured[i]) v = {v[30:0], captured[i]};
    return v;
  endfunction

  task automatic applyStimulus(input logic [1:0] p, input logic [3:0] l, input logic [14:0] d);
    @(negedge clk);
    port  = p;
    len   = l;
    data  = d;
    start = 1'b1;
    captured.delete();
    @(negedge clk);
    start = 1'b0;
  endtask

  task automatic waitIdle(input string name);
    int n = 0;
    while (busy && n < 500) begin
      @(negedge clk);
      n++;
    end
    if (busy) begin
      testsRun++;
      testsFailed++;
      $display("[TB] FAIL %s: busy still high after 500 cycles", name);
    end
    @(negedge clk);
  endtask

  task automatic waitBeats(input string name, input int beats);
    int n = 0;
    while (captured.size() < beats && n < 500) begin
      @(negedge clk);
      n++;
    end
    if (captured.size() < beats) begin
      testsRun++;
      testsFailed++;
      $display("[TB] FAIL %s: only %0d beats seen, needed %0d", name, captured.size(), beats);
    end
  endtask

  initial begin
    #1_000_000;
    $display("[TB] FAIL watchdog: simulation did not finish in time");
    $fatal(1);
  end

  initial begin
    logic [1:0] pv;

    // Reset held while clkEn keeps toggling.
    enDiv = 2;
    #1 rst = 1'b0;
    #2 checkEn = 1'b1;
    repeat (6) @(negedge clk);
    checkOutput("rstSerOut", 32'(SerOut), 32'd1);
    checkOutput("rstBusy", 32'(busy), 32'd0);
    checkOutput("rstFrameCnt", 32'(frameCnt), 32'd0);
    rst = 1'b1;
    repeat (4) @(negedge clk);
    checkOutput("postRstSerOut", 32'(SerOut), 32'd1);
    checkOutput("postRstDone", 32'(done), 32'd0);

    // Basic frame, clkEn every 4th clk.
    enDiv = 4;
    doneBefore = doneCount;
    applyStimulus(2'b10, 4'd3, 15'b101);
    waitIdle("basic");
    checkOutput("basicBeats", captured.size(), 32'd12);
    checkOutput("basicBits", packCaptured(), 32'b010001110111);
    checkOutput("basicDone", doneCount - doneBefore, 32'd1);
    checkOutput("basicFrameCnt", 32'(frameCnt), 32'd1);

    // Zero-length payload; upper data bits must not leak onto the line.
    enDiv = 3;
    doneBefore = doneCount;
    applyStimulus(2'b01, 4'd0, 15'h7FFF);
    waitIdle("zeroLen");
    checkOutput("zeroBeats", captured.size(), 32'd9);
    checkOutput("zeroBits", packCaptured(), 32'b001000011);
    checkOutput("zeroDone", doneCount - doneBefore, 32'd1);
    checkOutput("zeroFrameCnt", 32'(frameCnt), 32'd2);

    // Maximum length with clkEn held high.
    enDiv = 1;
    busyBefore = busyCycles;
    applyStimulus(2'b11, 4'd15, 15'h5555);
    waitIdle("maxLen");
    checkOutput("maxBeats", captured.size(), 32'd24);
    checkOutput("maxBits", packCaptured(), 32'b011111110101010101010111);
    checkOutput("maxBusyCycles", busyCycles - busyBefore, 32'd24);
    checkOutput("maxFrameCnt", 32'(frameCnt), 32'd3);

    // Second start during the payload must be ignored.
    enDiv = 2;
    doneBefore = doneCount;
    applyStimulus(2'b00, 4'd5, 15'b10110);
    waitBeats("rejectWait", 9);
    @(negedge clk);
    port  = 2'b11;
    start = 1'b1;
    repeat (3) @(negedge clk);
    start = 1'b0;
    waitIdle("reject");
    repeat (10) @(negedge clk);
    checkOutput("rejectBeats", captured.size(), 32'd14);
    checkOutput("rejectDone", doneCount - doneBefore, 32'd1);
    checkOutput("rejectBusy", 32'(busy), 32'd0);
    checkOutput("rejectFrameCnt", 32'(frameCnt), 32'd4);

    // Asynchronous reset while the length field is on the line.
    applyStimulus(2'b00, 4'd1, 15'h1);
    waitBeats("midRstWait", 4);
    @(negedge clk);
    checkOutput("midRstLineLow", 32'(SerOut), 32'd0);
    doneBefore = doneCount;
    #2 rst = 1'b0;
    #1;
    checkOutput("midRstSerOut", 32'(SerOut), 32'd1);
    checkOutput("midRstBusy", 32'(busy), 32'd0);
    checkOutput("midRstDone", 32'(done), 32'd0);
    checkOutput("midRstFrameCnt", 32'(frameCnt), 32'd0);
    repeat (3) @(negedge clk);
    rst = 1'b1;
    repeat (10) @(negedge clk);
    checkOutput("midRstNoDone", doneCount - doneBefore, 32'd0);
    checkOutput("midRstIdle", 32'(busy), 32'd0);

    // One frame to each port, back to back.
    enDiv = 1;
    doneBefore = doneCount;
    for (int p = 0; p < 4; p++) begin
      pv = 2'(p);
      applyStimulus(pv, 4'(2 + p), 15'($urandom));
      waitIdle("loop");
      checkOutput("loopBeats", captured.size(), 32'(11 + p));
      checkOutput("loopPortHi", 32'(captured[1]), 32'(pv[1]));
      checkOutput("loopPortLo", 32'(captured[2]), 32'(pv[0]));
    end
    checkOutput("loopDone", doneCount - doneBefore, 32'd4);
    checkOutput("loopFrameCnt", 32'(frameCnt), 32'd4);

    checkEn = 1'b0;
    $display("[TB] %0d tests run, %0d failed", testsRun, testsFailed);
    $finish;
  end

endmodule
